lc3_fetch_stage: RTL and testbench
==================================

Name: lc3_fetch_stage

Overview:
- LC-3 fetch stage; sits directly upstream of the decode stage.
- Owns the PC and issues instruction-memory reads. Captures each returned word and hands it to decode as instr_dout, npc_out and a one-cycle enable_decode pulse.
- Supports branch redirect: an in-flight read is discarded and fetch restarts at taddr.
- Supports a stall via enable_fetch.
- Memory read latency is fixed per build by a parameter.

Parameters:
- RESET_PC, 16'h3000: PC value after reset.
- MEM_LAT, 1: cycles from the instrmem_rd sample edge to the edge at which instrmem_dout is captured. Legal range 1..4.

Ports:
- clock  in  1: single clock; all logic on posedge.
- reset  in  1: synchronous, active-high.
- enable_fetch  in  1: controller permits new fetch requests.
- br_taken  in  1: redirect request, sampled every cycle.
- taddr  in  16: redirect target.
- instrmem_dout  in  16: instruction memory read data.
- instrmem_rd  out  1: memory read strobe; memory samples pc on the edge where this is 1.
- pc  out  16: instruction memory address (current PC).
- instr_dout  out  16: captured instruction to decode.
- npc_out  out  16: PC+1 of the captured instruction.
- enable_decode  out  1: one-cycle pulse, decode inputs valid.

Behaviour:
- Reset (any state, takes priority over everything):
  - state=IDLE, pc=RESET_PC, wait counter=0.
  - instr_dout=0, npc_out=0, enable_decode=0, instrmem_rd=0.
  - Data still returning from memory afterwards is ignored.
- States: IDLE, REQ, WAIT, DRAIN. instrmem_rd=1 only in REQ; it is decoded from state with no glitch paths.
- IDLE: if enable_fetch=1, next state is REQ; otherwise stay.
- REQ: lasts 1 cycle. Memory samples pc at the closing edge. Next state is WAIT with counter=MEM_LAT.
- WAIT:
  - Counter decrements each edge.
  - On the edge where the counter reaches 0 (the capture edge):
    - instr_dout<=instrmem_dout
    - npc_out<=pc+1
    - pc<=pc+1
    - enable_decode<=1 for exactly one cycle
  - Next state after capture is REQ if enable_fetch=1, else IDLE.
  - Issue period is MEM_LAT+1 cycles.
- enable_decode is 0 in every cycle except the one following a capture edge. instr_dout and npc_out hold between captures.
- Redirect (br_taken=1 at an edge; not reset):
  - pc<=taddr always.
  - IDLE: stay IDLE, or go to REQ if enable_fetch=1.
  - REQ: the read already issued with the old pc. Go to DRAIN with counter=MEM_LAT.
  - WAIT, including the capture edge: suppress capture. No enable_decode, instr_dout/npc_out unchanged. If the counter has not expired, go to DRAIN with the remaining count. At the capture edge itself, go directly to REQ/IDLE per enable_fetch.
  - DRAIN: a further br_taken updates pc only and the counter continues.
- DRAIN: counter decrements; returned data is discarded. At expiry, go to REQ if enable_fetch=1, else IDLE.
- Stall (enable_fetch=0):
  - Never starts a new REQ.
  - An outstanding read still completes and issues normally (WAIT), then the block goes to IDLE.
  - enable_fetch has no effect during REQ/WAIT/DRAIN except at exit.
- Arithmetic: pc+1 is 16-bit modulo, so 16'hFFFF increments to 16'h0000.
- Memory is single-outstanding; at most one read is in flight at any time.

Decomposition:
- Shared package lc3_pkg holds:
  - typedef word_t (logic [15:0])
  - enum fetch_state_e {IDLE, REQ, WAIT, DRAIN}
  - constant LC3_RESET_PC=16'h3000
- Sub-module fetch_pc_reg holds the PC register with reset/redirect/increment priority (reset > br_taken > capture increment). The FSM, counter and output registers stay in lc3_fetch_stage.

Test Plan:
1. Reset: hold reset 2 cycles with enable_fetch=1 and random instrmem_dout → pc=16'h3000; instrmem_rd, enable_decode, instr_dout and npc_out all 0; the first REQ occurs one cycle after reset deasserts.
2. Streaming, MEM_LAT=1: memory returns 16'h1261@3000, 16'h5020@3001, 16'h0E02@3002 → instrmem_rd high every 2nd cycle.
   - Pulse 1: instr_dout=16'h1261, npc_out=16'h3001.
   - Pulse 2: instr_dout=16'h5020, npc_out=16'h3002.
   - Pulse 3: instr_dout=16'h0E02, npc_out=16'h3003.
   - enable_decode pulses are 2 cycles apart.
3. Redirect in WAIT, MEM_LAT=3: br_taken=1, taddr=16'h3100 during the first WAIT cycle of the 16'h3001 fetch → no enable_decode for 3001; DRAIN for 2 cycles; next REQ has pc=16'h3100; issue gives npc_out=16'h3101.
4. Stall: drop enable_fetch during WAIT of 16'h3002 → that instruction still issues with npc_out=16'h3003, then IDLE with instrmem_rd=0. Re-raising enable_fetch 5 cycles later gives REQ at pc=16'h3003.
5. Wrap and capture-edge redirect:
   - Redirect to taddr=16'hFFFF, fetch 16'h1020 → npc_out=16'h0000 and pc=16'h0000.
   - br_taken exactly on a capture edge → no pulse, and the next REQ uses taddr.
6. Reset mid-WAIT, MEM_LAT=4: assert reset during the second WAIT cycle → no enable_decode ever for that read; pc=16'h3000; state IDLE; a stale instrmem_dout is not captured.

Source files
------------

// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared LC-3 types and constants for the fetch stage
package lc3_pkg;

   typedef logic [15:0] word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

   localparam word_t LC3_RESET_PC = 16'h3000;

   // Wide enough for the largest legal read latency (4).
   localparam int CNT_W = 3;
   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - LC-3 program counter register
// Priority: reset > redirect > capture increment (16-bit wrap).
module fetch_pc_reg
   import lc3_pkg::*;
#(
   parameter word_t RESET_PC = LC3_RESET_PC
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        redirect_i,
   input  logic [15:0] target_i,
   input  logic        incr_i,
   output logic [15:0] pc_o
);

   word_t pc_q;
   word_t pc_d;

   always_comb begin
      pc_d = pc_q;
      if (redirect_i) begin
         pc_d = target_i;
      end else if (incr_i) begin
         pc_d = pc_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/lc3_fetch_stage.sv
// rtl/lc3_fetch_stage.sv - LC-3 fetch stage: PC ownership, single-outstanding reads, decode handoff
// A redirect discards the in-flight read by draining its remaining latency.
module lc3_fetch_stage
   import lc3_pkg::*;
#(
   parameter word_t RESET_PC = LC3_RESET_PC,
   parameter int    MEM_LAT  = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable_fetch,
   input  logic        br_taken,
   input  logic [15:0] taddr,
   input  logic [15:0] instrmem_dout,
   output logic        instrmem_rd,
   output logic [15:0] pc,
   output logic [15:0] instr_dout,
   output logic [15:0] npc_out,
   output logic        enable_decode
);

   localparam cnt_t LAT_C = cnt_t'(MEM_LAT);
   localparam cnt_t ONE_C = cnt_t'(1);

   fetch_state_e state_q, state_d;
   cnt_t         cnt_q, cnt_d;
   logic         capture;
   logic         rd_q;
   word_t        instr_q;
   word_t        npc_q;
   logic         dec_q;
   word_t        pc_w;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (enable_fetch) state_d = REQ;
         end
         REQ: begin
            cnt_d   = LAT_C;
            state_d = br_taken ? DRAIN : WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q - ONE_C;
            if (cnt_q == ONE_C) begin
               capture = ~br_taken;
               state_d = enable_fetch ? REQ : IDLE;
            end else if (br_taken) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            cnt_d = cnt_q - ONE_C;
            if (cnt_q == ONE_C) begin
               state_d = enable_fetch ? REQ : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The read strobe is registered from the next state so it is glitch-free.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= (state_d == REQ);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         instr_q <= '0;
         npc_q   <= '0;
         dec_q   <= 1'b0;
      end else begin
         dec_q <= capture;
         if (capture) begin
            instr_q <= instrmem_dout;
            npc_q   <= pc_w + 16'd1;
         end
      end
   end

   fetch_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk_i      (clock),
      .rst_i      (reset),
      .redirect_i (br_taken),
      .target_i   (taddr),
      .incr_i     (capture),
      .pc_o       (pc_w)
   );

   assign instrmem_rd   = rd_q;
   assign pc            = pc_w;
   assign instr_dout    = instr_q;
   assign npc_out       = npc_q;
   assign enable_decode = dec_q;

endmodule

// File: tb/tb_lc3_fetch_stage.sv
// tb/tb_lc3_fetch_stage.sv - bench for lc3_fetch_stage at read latencies 1, 3 and 4
module tb_lc3_fetch_stage;

   localparam int NL = 3;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable_fetch;
   logic        br_taken;
   logic [15:0] taddr;

   logic [15:0] dout_l  [NL];
   logic        rd_l    [NL];
   logic [15:0] pc_l    [NL];
   logic [15:0] instr_l [NL];
   logic [15:0] npc_l   [NL];
   logic        dec_l   [NL];

   logic [15:0] mem [0:65535];
   logic [15:0] last_addr [NL];

   // Reference model: a pending-request flag, remaining read latency and a discard flag.
   logic [15:0] m_pc    [NL];
   logic        m_rd    [NL];
   int          m_left  [NL];
   logic        m_kill  [NL];
   logic [15:0] m_addr  [NL];
   logic [15:0] m_instr [NL];
   logic [15:0] m_npc   [NL];
   logic        m_dec   [NL];

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   always #5 clock = ~clock;

   genvar g;
   generate
      for (g = 0; g < NL; g++) begin : g_dut
         lc3_fetch_stage #(
            .RESET_PC (16'h3000),
            .MEM_LAT  ((g == 0) ? 1 : (g == 1) ? 3 : 4)
         ) u_dut (
            .clock         (clock),
            .reset         (reset),
            .enable_fetch  (enable_fetch),
            .br_taken      (br_taken),
            .taddr         (taddr),
            .instrmem_dout (dout_l[g]),
            .instrmem_rd   (rd_l[g]),
            .pc            (pc_l[g]),
            .instr_dout    (instr_l[g]),
            .npc_out       (npc_l[g]),
            .enable_decode (dec_l[g])
         );
      end
   endgenerate

   function automatic int lat_of(input int ln);
      return (ln == 0) ? 1 : (ln == 1) ? 3 : 4;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
      end
   endtask

   task automatic model_edge(input int i, input logic r, input logic ef, input logic br,
                             input logic [15:0] ta);
      logic nrd;
      if (r) begin
         m_pc[i] = 16'h3000; m_rd[i] = 1'b0; m_left[i] = 0; m_kill[i] = 1'b0;
         m_instr[i] = '0; m_npc[i] = '0; m_dec[i] = 1'b0;
         return;
      end
      nrd      = 1'b0;
      m_dec[i] = 1'b0;
      if (m_rd[i]) begin
         m_addr[i] = m_pc[i];
         m_left[i] = lat_of(i);
         m_kill[i] = br;
         if (br) m_pc[i] = ta;
      end else if (m_left[i] > 0) begin
         m_left[i]--;
         if (m_left[i] == 0) begin
            if (br) begin
               m_pc[i] = ta;
            end else if (!m_kill[i]) begin
               m_instr[i] = mem[m_addr[i]];
               m_npc[i]   = m_pc[i] + 16'd1;
               m_pc[i]    = m_pc[i] + 16'd1;
               m_dec[i]   = 1'b1;
            end
            nrd = ef;
         end else if (br) begin
            m_kill[i] = 1'b1;
            m_pc[i]   = ta;
         end
      end else begin
         if (br) m_pc[i] = ta;
         nrd = ef;
      end
      m_rd[i] = nrd;
   endtask

   task automatic step(input logic r, input logic ef, input logic br, input logic [15:0] ta);
      logic [15:0] pre_pc [NL];
      logic        pre_rd [NL];
      reset = r; enable_fetch = ef; br_taken = br; taddr = ta;
      for (int i = 0; i < NL; i++) dout_l[i] = mem[last_addr[i]];
      #1;
      for (int i = 0; i < NL; i++) begin
         pre_pc[i] = pc_l[i];
         pre_rd[i] = rd_l[i];
      end
      @(posedge clock);
      #1;
      cycle++;
      for (int i = 0; i < NL; i++) begin
         if (pre_rd[i]) last_addr[i] = pre_pc[i];
         model_edge(i, r, ef, br, ta);
         check($sformatf("lane%0d_outputs", i),
               {14'd0, pc_l[i], rd_l[i], dec_l[i], instr_l[i], npc_l[i]},
               {14'd0, m_pc[i], m_rd[i], m_dec[i], m_instr[i], m_npc[i]});
      end
      @(negedge clock);
   endtask

   task automatic wait_for_dec(input int ln, input int maxc, output logic ok);
      int k;
      ok = 1'b0;
      k  = 0;
      while (!ok && k < maxc) begin
         step(1'b0, 1'b1, 1'b0, 16'h0);
         if (dec_l[ln]) ok = 1'b1;
         k++;
      end
   endtask

   task automatic do_reset(input logic ef);
      step(1'b1, ef, 1'b0, 16'h0);
      step(1'b1, ef, 1'b0, 16'h0);
   endtask

   logic        ok;
   int          t_prev;
   logic [15:0] exp_i [3];

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
      for (int i = 0; i < NL; i++) last_addr[i] = 16'h0;
      mem[16'h3000] = 16'h1261;
      mem[16'h3001] = 16'h5020;
      mem[16'h3002] = 16'h0E02;
      mem[16'h3100] = 16'h5B1F;
      mem[16'hFFFF] = 16'h1020;
      exp_i[0] = 16'h1261; exp_i[1] = 16'h5020; exp_i[2] = 16'h0E02;
      reset = 1'b1; enable_fetch = 1'b0; br_taken = 1'b0; taddr = 16'h0;
      @(negedge clock);

      // Reset with fetch enabled
      do_reset(1'b1);
      for (int i = 0; i < NL; i++) begin
         check("rst_pc", pc_l[i], 16'h3000);
         check("rst_rd_dec", {rd_l[i], dec_l[i]}, 2'b00);
         check("rst_instr_npc", {instr_l[i], npc_l[i]}, 32'h0);
      end
      step(1'b0, 1'b1, 1'b0, 16'h0);
      check("first_req_rd", rd_l[0], 1'b1);
      check("first_req_pc", pc_l[0], 16'h3000);

      // Streaming at latency 1
      t_prev = cycle;
      for (int p = 0; p < 3; p++) begin
         wait_for_dec(0, 12, ok);
         check("stream_pulse_seen", ok, 1'b1);
         check("stream_instr", instr_l[0], exp_i[p]);
         check("stream_npc", npc_l[0], 16'h3001 + 16'(p));
         if (p > 0) check("stream_spacing", cycle - t_prev, 2);
         t_prev = cycle;
      end

      // Redirect during first WAIT cycle at latency 3
      do_reset(1'b1);
      step(1'b0, 1'b1, 1'b0, 16'h0);
      wait_for_dec(1, 12, ok);
      check("redir_first_pulse", {ok, npc_l[1]}, {1'b1, 16'h3001});
      step(1'b0, 1'b1, 1'b0, 16'h0);
      step(1'b0, 1'b1, 1'b1, 16'h3100);
      check("redir_drain1", {rd_l[1], dec_l[1]}, 2'b00);
      step(1'b0, 1'b1, 1'b0, 16'h0);
      check("redir_drain2", {rd_l[1], dec_l[1]}, 2'b00);
      step(1'b0, 1'b1, 1'b0, 16'h0);
      check("redir_req", {rd_l[1], pc_l[1]}, {1'b1, 16'h3100});
      wait_for_dec(1, 12, ok);
      check("redir_issue", {ok, instr_l[1], npc_l[1]}, {1'b1, 16'h5B1F, 16'h3101});

      // Stall during WAIT at latency 1
      do_reset(1'b1);
      step(1'b0, 1'b1, 1'b0, 16'h0);
      wait_for_dec(0, 12, ok);
      wait_for_dec(0, 12, ok);
      check("stall_pre", {ok, npc_l[0]}, {1'b1, 16'h3002});
      step(1'b0, 1'b1, 1'b0, 16'h0);
      step(1'b0, 1'b0, 1'b0, 16'h0);
      check("stall_issue", {dec_l[0], instr_l[0], npc_l[0]}, {1'b1, 16'h0E02, 16'h3003});
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b0, 1'b0, 16'h0);
         check("stall_idle_rd", {rd_l[0], dec_l[0]}, 2'b00);
      end
      check("stall_pc", pc_l[0], 16'h3003);
      step(1'b0, 1'b1, 1'b0, 16'h0);
      check("stall_resume", {rd_l[0], pc_l[0]}, {1'b1, 16'h3003});

      // Wrap at FFFF, then redirect on the capture edge
      do_reset(1'b0);
      step(1'b0, 1'b0, 1'b1, 16'hFFFF);
      check("wrap_redir_idle", {rd_l[0], pc_l[0]}, {1'b0, 16'hFFFF});
      step(1'b0, 1'b1, 1'b0, 16'h0);
      check("wrap_req", {rd_l[0], pc_l[0]}, {1'b1, 16'hFFFF});
      wait_for_dec(0, 12, ok);
      check("wrap_issue", {ok, instr_l[0], npc_l[0], pc_l[0]}, {1'b1, 16'h1020, 16'h0000, 16'h0000});
      step(1'b0, 1'b1, 1'b0, 16'h0);
      step(1'b0, 1'b1, 1'b1, 16'h4242);
      check("capedge_redir", {dec_l[0], rd_l[0], pc_l[0]}, {1'b0, 1'b1, 16'h4242});
      check("capedge_hold", npc_l[0], 16'h0000);

      // Reset during second WAIT cycle at latency 4
      do_reset(1'b1);
      step(1'b0, 1'b1, 1'b0, 16'h0);
      check("rstwait_req", rd_l[2], 1'b1);
      step(1'b0, 1'b1, 1'b0, 16'h0);
      step(1'b0, 1'b1, 1'b0, 16'h0);
      step(1'b1, 1'b1, 1'b0, 16'h0);
      check("rstwait_state", {pc_l[2], rd_l[2], dec_l[2], instr_l[2], npc_l[2]},
            {16'h3000, 1'b0, 1'b0, 16'h0, 16'h0});
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 1'b0, 1'b0, 16'h0);
         check("rstwait_no_capture", {rd_l[2], dec_l[2], instr_l[2]}, {1'b0, 1'b0, 16'h0});
      end

      // Randomised traffic against the model
      for (int k = 0; k < 800; k++) begin
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 7) == 0), 16'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
